// File: rtl/key_expand_seq.sv
// AES-128 key schedule: one round key per clock into an 11 x 128-bit register file.
// Latency: done pulses in the 11th cycle after the start edge; start is ignored while busy.

module gen_key (
   input  logic [127:0] key_in,
   input  logic [3:0]   round,
   output logic [127:0] key_out
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Table is stored first-entry-in-MSB, so entry x sits at byte (255 - x) from the LSB.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[(255 - int'(x)) * 8 +: 8];
   endfunction

   logic [31:0] w0, w1, w2, w3, rot, sub, rcon, n0, n1, n2, n3;

   always_comb begin
      case (round)
         4'd0:    rcon = 32'h01000000;
         4'd1:    rcon = 32'h02000000;
         4'd2:    rcon = 32'h04000000;
         4'd3:    rcon = 32'h08000000;
         4'd4:    rcon = 32'h10000000;
         4'd5:    rcon = 32'h20000000;
         4'd6:    rcon = 32'h40000000;
         4'd7:    rcon = 32'h80000000;
         4'd8:    rcon = 32'h1b000000;
         4'd9:    rcon = 32'h36000000;
         default: rcon = 32'h00000000;
      endcase
      {w0, w1, w2, w3} = key_in;
      rot = {w3[23:0], w3[31:24]};
      sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      n0  = w0 ^ sub ^ rcon;
      n1  = n0 ^ w1;
      n2  = n1 ^ w2;
      n3  = n2 ^ w3;
      key_out = {n0, n1, n2, n3};
   end
endmodule

module key_expand_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         key_valid,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key
);
   typedef enum logic {IDLE, EXPAND} state_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         key_valid_q, key_valid_d;
   logic [127:0] slots_q [11];
   logic [127:0] slots_d [11];
   logic [127:0] rd_key_q, rd_key_d;
   logic [127:0] cur_key, next_key;

   gen_key u_gen_key (
      .key_in  (cur_key),
      .round   (cnt_q),
      .key_out (next_key)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      key_valid_d = key_valid_q;
      slots_d     = slots_q;
      cur_key     = (cnt_q <= 4'd10) ? slots_q[cnt_q] : '0;
      rd_key_d    = (rd_round <= 4'd10) ? slots_q[rd_round] : '0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               slots_d[0]  = key_in;
               cnt_d       = 4'd0;
               busy_d      = 1'b1;
               key_valid_d = 1'b0;
               state_d     = EXPAND;
            end
         end
         EXPAND: begin
            for (int k = 1; k < 11; k++) begin
               if (cnt_q == 4'(k - 1)) slots_d[k] = next_key;
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               state_d     = IDLE;
               busy_d      = 1'b0;
               key_valid_d = 1'b1;
               done_d      = 1'b1;
            end else if (cnt_q > 4'd9) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               cnt_d   = cnt_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // Unreachable counter codes park the machine rather than index past the file.
      if (cnt_q > 4'd10) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         key_valid_q <= 1'b0;
         rd_key_q    <= '0;
         for (int k = 0; k < 11; k++) slots_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         key_valid_q <= key_valid_d;
         rd_key_q    <= rd_key_d;
         slots_q     <= slots_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign key_valid = key_valid_q;
   assign rd_key    = rd_key_q;
endmodule

// File: tb/tb_key_expand_seq.sv
// Self-checking bench for key_expand_seq: reference key schedule built from GF(2^8) arithmetic.
module tb_key_expand_seq;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy, done, key_valid;
   logic [3:0]   rd_round;
   logic [127:0] rd_key;

   key_expand_seq dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in),
      .busy(busy), .done(done), .key_valid(key_valid),
      .rd_round(rd_round), .rd_key(rd_key)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [127:0] key;
      logic [127:0] exp1;
      logic [127:0] exp10;
   } vec_t;
   vec_t vecs [4];

   logic [127:0] sched [11];
   logic [127:0] exp_q [$];
   string        nm_q  [$];

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] sb_m(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] m_next(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {w3[23:0], w3[31:24]};
      t  = {sb_m(t[31:24]), sb_m(t[23:16]), sb_m(t[15:8]), sb_m(t[7:0])};
      w0 = w0 ^ t ^ {rc, 24'h0};
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic void build_sched(input logic [127:0] k);
      logic [7:0] rc;
      rc = 8'h01;
      sched[0] = k;
      for (int r = 1; r < 11; r++) begin
         sched[r] = m_next(sched[r - 1], rc);
         rc = gmul(rc, 8'h02);
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk1(input logic act, input logic exp, input string nm);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic chk128(input logic [127:0] act, input logic [127:0] exp, input string nm);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chkint(input int act, input int exp, input string nm);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic rd_issue(input logic [3:0] idx, input logic [127:0] e, input string nm);
      rd_round = idx;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic rd_drain();
      if (exp_q.size() > 0) chk128(rd_key, exp_q.pop_front(), nm_q.pop_front());
   endtask

   task automatic run_expand(input logic [127:0] k, input string nm);
      int n;
      @(negedge clk);
      key_in = k;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      chk1(busy, 1'b1, {nm, "_busy"});
      chk1(key_valid, 1'b0, {nm, "_kv_low"});
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
      chkint(n, 11, {nm, "_latency"});
      chk1(key_valid, 1'b1, {nm, "_kv_at_done"});
      chk1(busy, 1'b0, {nm, "_busy_at_done"});
      @(negedge clk);
      chk1(done, 1'b0, {nm, "_done_pulse"});
      chk1(key_valid, 1'b1, {nm, "_kv_hold"});
   endtask

   task automatic check_slots(input logic [127:0] e1, input logic [127:0] e10, input string nm);
      @(negedge clk); rd_drain(); rd_issue(4'd1, e1, {nm, "_slot1"});
      @(negedge clk); rd_drain(); rd_issue(4'd10, e10, {nm, "_slot10"});
      @(negedge clk); rd_drain();
   endtask

   task automatic sweep(input string nm);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rd_drain();
         rd_issue(4'(i), (i <= 10) ? sched[i] : 128'h0, $sformatf("%s_rd%0d", nm, i));
      end
      @(negedge clk);
      rd_drain();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n, dcnt, dfirst, kv_cnt;
      logic [127:0] key_b;

      vecs[0] = '{FIPS_KEY, 128'ha0fafe1788542cb123a339392a6c7605,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{128'h0, 128'h62636363626363636263636362636363,
                  128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      for (int i = 2; i < 4; i++) begin
         vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
         build_sched(vecs[i].key);
         vecs[i].exp1  = sched[1];
         vecs[i].exp10 = sched[10];
      end

      rst = 1'b1; start = 1'b1; key_in = FIPS_KEY; rd_round = 4'd0;
      repeat (3) @(negedge clk);
      chk1(busy, 1'b0, "rst_busy");
      chk1(done, 1'b0, "rst_done");
      chk1(key_valid, 1'b0, "rst_kv");
      chk128(rd_key, 128'h0, "rst_rdkey");
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk1(busy, 1'b0, "idle_busy");

      foreach (vecs[i]) begin
         run_expand(vecs[i].key, $sformatf("vec%0d", i));
         check_slots(vecs[i].exp1, vecs[i].exp10, $sformatf("vec%0d", i));
         build_sched(vecs[i].key);
         sweep($sformatf("vec%0d", i));
      end

      // Extra start pulses while busy must not restart or queue.
      @(negedge clk);
      key_in = FIPS_KEY; start = 1'b1;
      dcnt = 0; dfirst = 0;
      for (n = 1; n < 17; n++) begin
         @(negedge clk);
         if (done) begin
            dcnt++;
            if (dfirst == 0) dfirst = n;
         end
         start  = (n == 3 || n == 7);
         key_in = (n == 3 || n == 7) ? 128'hdeadbeef0123456789abcdeffedcba98 : FIPS_KEY;
      end
      start = 1'b0;
      chkint(dcnt, 1, "busy_start_done_count");
      chkint(dfirst, 11, "busy_start_done_cycle");
      check_slots(vecs[0].exp1, vecs[0].exp10, "busy_start");

      // Read of a slot on the edge it is rewritten returns the old content.
      @(negedge clk);
      key_in = 128'h0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rd_issue(4'd1, vecs[0].exp1, "same_edge_old");
      @(negedge clk); rd_drain(); rd_issue(4'd1, vecs[1].exp1, "same_edge_new");
      @(negedge clk); rd_drain();
      n = 0;
      while (!done && n < 30) begin @(negedge clk); n++; end
      chk1(done, 1'b1, "same_edge_done");

      // Reset in the middle of an expansion.
      @(negedge clk);
      rd_round = 4'd0; key_in = FIPS_KEY; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk128(rd_key, FIPS_KEY, "pre_rst_rdkey");
      rst = 1'b1;
      #1;
      chk1(busy, 1'b0, "midrst_busy");
      chk1(key_valid, 1'b0, "midrst_kv");
      chk128(rd_key, 128'h0, "midrst_rdkey");
      @(negedge clk);
      rst = 1'b0;
      run_expand(FIPS_KEY, "after_rst");
      check_slots(vecs[0].exp1, vecs[0].exp10, "after_rst");

      // Back-to-back: start held through done, new key taken on the following edge.
      key_b = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      key_in = vecs[1].key; start = 1'b1;
      n = 0;
      while (!done && n < 30) begin @(negedge clk); n++; end
      chkint(n, 11, "b2b_first_latency");
      key_in = key_b;
      kv_cnt = 0;
      for (int j = 0; j < 10; j++) begin
         if (key_valid) kv_cnt++;
         @(negedge clk);
         start = 1'b0;
      end
      chkint(kv_cnt, 1, "b2b_kv_cycles");
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      chk1(done, 1'b1, "b2b_second_done");
      chk1(key_valid, 1'b1, "b2b_second_kv");
      build_sched(key_b);
      sweep("b2b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end
endmodule

// File: doc/key_expand_seq.md
KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 The block SHALL have no parameters; round count is fixed at 10 (AES-128).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request expansion of key_in; sampled only in IDLE.
REQ-005 key_in  input  128  cipher key, bit 127 = first key byte MSB; sampled on the same edge as start.
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 done  output  1  one-cycle pulse when all 11 round keys are stored.
REQ-008 key_valid  output  1  level; high while the 11 stored round keys form a complete, consistent set.
REQ-009 rd_round  input  4  round-key index to read, 0..10.
REQ-010 rd_key  output  128  registered round key selected by rd_round.

Function
REQ-011 Storage SHALL be an 11-entry x 128-bit register file, slot k = round key k, slot 0 = cipher key.
REQ-012 FSM states SHALL be IDLE and EXPAND only.
REQ-013 IDLE with start=1 at edge E0: slot0 <= key_in, round counter <= 0, busy <= 1, key_valid <= 0, next state EXPAND.
REQ-014 IDLE with start=0: no state change; slots hold.
REQ-015 EXPAND, edge Ek (k = 1..10): slot[k] <= next-round key computed from slot[k-1] with round index k-1; counter increments.
REQ-016 Round-key step SHALL be the standard AES-128 expansion: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon, wi' = wi-1' ^ wi; the step SHALL reuse the existing gen_key block, driven with round = counter.
REQ-017 Rcon by round index 0..9 SHALL be 01,02,04,08,10,20,40,80,1b,36 in the top byte, other bytes zero.
REQ-018 One round key SHALL be produced per clock; no stalls.
REQ-019 At E10: state <= IDLE, busy <= 0, key_valid <= 1, done <= 1; done SHALL clear at E11.
REQ-020 Total latency: done is high in the 11th cycle after the start edge, i.e. between E10 and E11.
REQ-021 start asserted while busy=1 SHALL be ignored; no restart, no queueing.
REQ-022 start asserted in the same cycle that done is high (state IDLE) SHALL be accepted and begin a new expansion.
REQ-023 A new start SHALL drop key_valid at E0 even if a previous set was valid.
REQ-024 rd_key <= slot[rd_round] on every edge; 1-cycle read latency; read is allowed in any state.
REQ-025 rd_round in 11..15 SHALL give rd_key <= 0.
REQ-026 A read of a slot on the same edge it is written SHALL return the old content.
REQ-027 The counter SHALL never exceed 10; unused counter encodings SHALL force IDLE.

Reset
REQ-028 While rst=1, regardless of clk: state = IDLE, counter = 0, all slots = 0, busy = 0, done = 0, key_valid = 0, rd_key = 0.
REQ-029 Reset asserted mid-expansion SHALL abort the expansion; no partial set is reported valid.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-031 key_in = 2b7e151628aed2a6abf7158809cf4f3c, start for 1 cycle -> done exactly 11 cycles later; slot1 = a0fafe1788542cb123a339392a6c7605, slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 key_in = 0 -> slot1 = 62636363626363636263636362636363, slot10 = b4ef5bcb3e92e21123e951cf6f8f188e, key_valid = 1 after done.
REQ-033 start pulsed at cycles 3 and 7 after the first start -> single done at cycle 11, results identical to REQ-031.
REQ-034 rst asserted at cycle 5 of expansion -> busy, key_valid and rd_key are 0 immediately; restart with the REQ-031 key gives the REQ-031 results.
REQ-035 rd_round sweep 0..15 after done -> rd_key one cycle later equals slot 0..10, then 0 for indices 11..15.
REQ-036 Back-to-back: start held high through done -> key_valid pulses high for exactly one cycle; the second set matches the new key_in.
